// File: rtl/fp_add_mul_unit.sv
// Registered 8-bit minifloat multiply and add/subtract unit: both results come from one
// operand pair and are presented together one cycle after in_valid.
module fp_add_mul_unit #(
    parameter int WIDTH      = 8,
    parameter int EXP_WIDTH  = 3,
    parameter int MANT_WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             control,
    input  logic             RoundU,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_sum,
    output logic [5:0]       flags_mul,
    output logic [5:0]       flags_add
);
    localparam int EW   = EXP_WIDTH;
    localparam int MW   = MANT_WIDTH;
    localparam int SW   = MW + 1;
    localparam int PW   = 2 * SW;
    localparam int XW   = EW + 2;
    localparam int LW   = $clog2(PW + 1);
    localparam int BIAS = 2 ** (EW - 1) - 1;
    localparam int RW   = WIDTH + 6;

    localparam logic [XW-1:0]    EXP_TOP = XW'(2 ** EW - 1);
    localparam logic [XW-1:0]    MUL_OFF = XW'(BIAS + 2 * MW);
    localparam logic [WIDTH-1:0] QNAN    = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
    localparam logic [WIDTH-2:0] INF_MAG = {{EW{1'b1}}, {MW{1'b0}}};
    localparam logic [WIDTH-2:0] MAX_MAG = {{(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};

    // sig carries the hidden bit at PW-1; be is the biased exponent of that bit (>= 1).
    function automatic logic [RW-1:0] round_pack(
        input logic          s,
        input logic [XW-1:0] be,
        input logic [PW-1:0] sig,
        input logic          sticky,
        input logic          tiny,
        input logic          rnd
    );
        logic [SW-1:0]    kept;
        logic             g;
        logic             st;
        logic             inexact;
        logic             inc;
        logic [SW:0]      rs;
        logic [XW-1:0]    ex;
        logic [MW-1:0]    fr;
        logic [5:0]       fl;
        logic [WIDTH-1:0] r;
        kept    = sig[PW-1 -: SW];
        g       = sig[PW-SW-1];
        st      = (|sig[PW-SW-2:0]) | sticky;
        inexact = g | st;
        inc     = rnd & g & (st | kept[0]);
        rs      = {1'b0, kept} + {{SW{1'b0}}, inc};
        if (rs[SW]) begin
            ex = be + XW'(1);
            fr = '0;
        end else begin
            ex = rs[SW-1] ? be : '0;
            fr = rs[MW-1:0];
        end
        if (ex >= EXP_TOP) begin
            r  = rnd ? {s, INF_MAG} : {s, MAX_MAG};
            fl = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, rnd};
        end else begin
            r  = {s, ex[EW-1:0], fr};
            fl = {1'b0, 1'b0, tiny & inexact, inexact, (ex == '0) && (fr == '0), 1'b0};
        end
        return {fl, r};
    endfunction

    logic          a_s, b_s, b_se;
    logic [EW-1:0] a_e, b_e, a_eu, b_eu;
    logic [MW-1:0] a_f, b_f;
    logic [SW-1:0] a_sig, b_sig;
    logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign {a_s, a_e, a_f} = a;
    assign {b_s, b_e, b_f} = b;
    assign b_se   = b_s ^ control;
    assign a_nan  = (a_e == '1) && (a_f != '0);
    assign b_nan  = (b_e == '1) && (b_f != '0);
    assign a_inf  = (a_e == '1) && (a_f == '0);
    assign b_inf  = (b_e == '1) && (b_f == '0);
    assign a_zero = (a_e == '0) && (a_f == '0);
    assign b_zero = (b_e == '0) && (b_f == '0);
    assign a_sig  = {a_e != '0, a_f};
    assign b_sig  = {b_e != '0, b_f};
    assign a_eu   = (a_e == '0) ? EW'(1) : a_e;
    assign b_eu   = (b_e == '0) ? EW'(1) : b_e;

    // Multiply: normalise the product, then denormalise into the subnormal range if needed.
    logic [PW-1:0]   m_prod, m_norm, m_sig;
    logic [LW-1:0]   m_lead;
    logic [XW-1:0]   m_esum, m_t, m_sh, m_be;
    logic [2*PW-1:0] m_wide;
    logic            m_tiny, m_sticky;

    always_comb begin
        m_prod = {{SW{1'b0}}, a_sig} * {{SW{1'b0}}, b_sig};
        m_lead = '0;
        for (int i = 0; i < PW; i++) begin
            if (m_prod[i]) m_lead = LW'(i);
        end
        m_norm = m_prod << (LW'(PW - 1) - m_lead);
        m_esum = XW'(a_eu) + XW'(b_eu);
        m_t    = XW'(m_lead) + m_esum;
        m_tiny = (m_t <= MUL_OFF);
        m_sh   = MUL_OFF + XW'(1) - m_t;
        m_wide = {m_norm, {PW{1'b0}}} >> m_sh;
        if (m_tiny) begin
            m_sig    = m_wide[2*PW-1:PW];
            m_sticky = |m_wide[PW-1:0];
            m_be     = XW'(1);
        end else begin
            m_sig    = m_norm;
            m_sticky = 1'b0;
            m_be     = m_t - MUL_OFF;
        end
    end

    // Add/sub: align the smaller magnitude under the larger one; the extra low bits keep it exact.
    logic          a_big, big_s, sml_s, eff_sub;
    logic [EW-1:0] big_eu, sml_eu, s_d;
    logic [SW-1:0] big_sig, sml_sig;
    logic [PW-1:0] big_ext, sml_ext, s_sig;
    logic [PW:0]   s_mag;
    logic [LW-1:0] s_lead, s_nshift, s_lim, s_amt;
    logic [XW-1:0] s_be;
    logic          s_sticky, s_tiny;

    always_comb begin
        a_big   = {a_eu, a_sig} >= {b_eu, b_sig};
        big_s   = a_big ? a_s   : b_se;
        sml_s   = a_big ? b_se  : a_s;
        big_eu  = a_big ? a_eu  : b_eu;
        sml_eu  = a_big ? b_eu  : a_eu;
        big_sig = a_big ? a_sig : b_sig;
        sml_sig = a_big ? b_sig : a_sig;
        s_d     = big_eu - sml_eu;
        big_ext = {big_sig, {SW{1'b0}}};
        sml_ext = {sml_sig, {SW{1'b0}}} >> s_d;
        eff_sub = big_s ^ sml_s;
        s_mag   = eff_sub ? ({1'b0, big_ext} - {1'b0, sml_ext})
                          : ({1'b0, big_ext} + {1'b0, sml_ext});
        s_lead  = '0;
        for (int i = 0; i <= PW; i++) begin
            if (s_mag[i]) s_lead = LW'(i);
        end
        s_nshift = LW'(PW - 1) - s_lead;
        s_lim    = LW'(big_eu) - LW'(1);
        s_amt    = (s_nshift < s_lim) ? s_nshift : s_lim;
        if (s_mag[PW]) begin
            s_sig    = s_mag[PW:1];
            s_sticky = s_mag[0];
            s_be     = XW'(big_eu) + XW'(1);
        end else begin
            s_sig    = s_mag[PW-1:0] << s_amt;
            s_sticky = 1'b0;
            s_be     = XW'(big_eu) - XW'(s_amt);
        end
        s_tiny = ~s_sig[PW-1];
    end

    logic          mul_s;
    logic [RW-1:0] mul_res, add_res;

    assign mul_s = a_s ^ b_s;

    always_comb begin
        mul_res = round_pack(mul_s, m_be, m_sig, m_sticky, m_tiny, RoundU);
        if (a_nan || b_nan) begin
            mul_res = {6'b000000, QNAN};
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            mul_res = {6'b100000, QNAN};
        end else if (a_inf || b_inf) begin
            mul_res = {6'b000001, mul_s, INF_MAG};
        end else if (a_zero || b_zero) begin
            mul_res = {6'b000010, mul_s, {(WIDTH-1){1'b0}}};
        end
    end

    always_comb begin
        add_res = round_pack(big_s, s_be, s_sig, s_sticky, s_tiny, RoundU);
        if (a_nan || b_nan) begin
            add_res = {6'b000000, QNAN};
        end else if (a_inf && b_inf && (a_s != b_se)) begin
            add_res = {6'b100000, QNAN};
        end else if (a_inf) begin
            add_res = {6'b000001, a_s, INF_MAG};
        end else if (b_inf) begin
            add_res = {6'b000001, b_se, INF_MAG};
        end else if (s_mag == '0) begin
            // Exact cancellation is +0; only two negative zeros keep the sign.
            add_res = {6'b000010, a_s & b_se, {(WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            y         <= '0;
            y_sum     <= '0;
            flags_mul <= '0;
            flags_add <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y         <= mul_res[WIDTH-1:0];
                flags_mul <= mul_res[RW-1:WIDTH];
                y_sum     <= add_res[WIDTH-1:0];
                flags_add <= add_res[RW-1:WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_fp_add_mul_unit.sv
// Bench for fp_add_mul_unit: reference model works on exact scaled integers and
// rounds by quantum division; results are matched through an expected queue.
module tb_fp_add_mul_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] a, b;
    logic       control, RoundU;
    logic       out_valid;
    logic [7:0] y, y_sum;
    logic [5:0] flags_mul, flags_add;

    int n_cmp = 0;
    int n_err = 0;
    logic [27:0] exp_q[$];
    logic [27:0] last_exp;

    fp_add_mul_unit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .control   (control),
        .RoundU    (RoundU),
        .out_valid (out_valid),
        .y         (y),
        .y_sum     (y_sum),
        .flags_mul (flags_mul),
        .flags_add (flags_add)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int mag6(input logic [7:0] x);
        if (x[6:4] == 3'd0) return int'(x[3:0]);
        return (16 + int'(x[3:0])) << (int'(x[6:4]) - 1);
    endfunction

    function automatic logic is_nan(input logic [7:0] x);
        return (x[6:4] == 3'b111) && (x[3:0] != 4'd0);
    endfunction

    function automatic logic is_inf(input logic [7:0] x);
        return x[6:0] == 7'b1110000;
    endfunction

    function automatic logic is_zero(input logic [7:0] x);
        return x[6:0] == 7'd0;
    endfunction

    // m is the exact magnitude in units of 2^-12; returns {flags, encoding}.
    function automatic logic [13:0] model_round(input logic s, input int m, input logic rnd);
        int e_eff, q, n, r;
        logic inexact, tiny;
        logic [5:0] fl;
        logic [7:0] yy;
        e_eff = 1;
        for (int e = 2; e <= 12; e++) begin
            if (m >= (1 << (e + 9))) e_eff = e;
        end
        q = 1 << (e_eff + 5);
        n = m / q;
        r = m % q;
        inexact = (r != 0);
        tiny = (m < 1024);
        if (rnd && ((2 * r > q) || ((2 * r == q) && (n % 2 == 1)))) n++;
        if (n == 32) begin
            n = 16;
            e_eff++;
        end
        if (e_eff >= 7) begin
            if (rnd) return {6'b010101, s, 7'b1110000};
            return {6'b010100, s, 7'b1101111};
        end
        if (n >= 16) yy = {s, 3'(e_eff), 4'(n - 16)};
        else         yy = {s, 3'b000, 4'(n)};
        fl = {2'b00, tiny & inexact, inexact, n == 0, 1'b0};
        return {fl, yy};
    endfunction

    function automatic logic [13:0] model_mul(input logic [7:0] x, input logic [7:0] z, input logic rnd);
        logic s;
        s = x[7] ^ z[7];
        if (is_nan(x) || is_nan(z)) return {6'b000000, 8'h78};
        if ((is_inf(x) && is_zero(z)) || (is_zero(x) && is_inf(z))) return {6'b100000, 8'h78};
        if (is_inf(x) || is_inf(z)) return {6'b000001, s, 7'b1110000};
        if (is_zero(x) || is_zero(z)) return {6'b000010, s, 7'd0};
        return model_round(s, mag6(x) * mag6(z), rnd);
    endfunction

    function automatic logic [13:0] model_add(input logic [7:0] x, input logic [7:0] z,
                                               input logic ctl, input logic rnd);
        logic sz;
        int vx, vz, sum;
        sz = z[7] ^ ctl;
        if (is_nan(x) || is_nan(z)) return {6'b000000, 8'h78};
        if (is_inf(x) && is_inf(z) && (x[7] != sz)) return {6'b100000, 8'h78};
        if (is_inf(x)) return {6'b000001, x[7], 7'b1110000};
        if (is_inf(z)) return {6'b000001, sz, 7'b1110000};
        vx = x[7] ? -mag6(x) : mag6(x);
        vz = sz ? -mag6(z) : mag6(z);
        sum = vx + vz;
        if (sum == 0) return {6'b000010, x[7] & sz, 7'd0};
        if (sum < 0) return model_round(1'b1, -sum * 64, rnd);
        return model_round(1'b0, sum * 64, rnd);
    endfunction

    task automatic send_pair(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                             input logic tr, input logic [27:0] e);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = ta;
        b = tb;
        control = tc;
        RoundU = tr;
        exp_q.push_back(e);
        last_exp = e;
    endtask

    task automatic drive_pair(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic tr);
        logic [13:0] m, s;
        m = model_mul(ta, tb, tr);
        s = model_add(ta, tb, tc, tr);
        send_pair(ta, tb, tc, tr, {m[7:0], m[13:8], s[7:0], s[13:8]});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, 8'(exp_q.size()), 8'd0);
    endtask

    always @(negedge clk) begin
        logic [27:0] e;
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", {7'd0, out_valid}, 8'd0);
            end else begin
                e = exp_q.pop_front();
                check("y", y, e[27:20]);
                check("flags_mul", {2'b00, flags_mul}, {2'b00, e[19:14]});
                check("y_sum", y_sum, e[13:6]);
                check("flags_add", {2'b00, flags_add}, {2'b00, e[5:0]});
            end
        end
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        control = 1'b0;
        RoundU = 1'b0;
        last_exp = '0;
        #12;
        check("rst_out_valid", {7'd0, out_valid}, 8'd0);
        check("rst_y", y, 8'd0);
        check("rst_y_sum", y_sum, 8'd0);
        check("rst_flags_mul", {2'b00, flags_mul}, 8'd0);
        check("rst_flags_add", {2'b00, flags_add}, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        send_pair(8'hEF, 8'h6F, 1'b0, 1'b1, {8'hF0, 6'b010101, 8'h00, 6'b000010});
        send_pair(8'hEF, 8'h6F, 1'b1, 1'b1, {8'hF0, 6'b010101, 8'hF0, 6'b010101});
        send_pair(8'h12, 8'h22, 1'b0, 1'b1, {8'h0A, 6'b001100, 8'h2B, 6'b000000});
        send_pair(8'h12, 8'h22, 1'b1, 1'b1, {8'h0A, 6'b001100, 8'h92, 6'b000000});
        send_pair(8'hA5, 8'h00, 1'b0, 1'b1, {8'h80, 6'b000010, 8'hA5, 6'b000000});
        send_pair(8'hEF, 8'h6F, 1'b0, 1'b0, {8'hEF, 6'b010100, 8'h00, 6'b000010});
        send_pair(8'h70, 8'h70, 1'b1, 1'b1, {8'h70, 6'b000001, 8'h78, 6'b100000});
        send_pair(8'h79, 8'h30, 1'b0, 1'b1, {8'h78, 6'b000000, 8'h78, 6'b000000});
        send_pair(8'h00, 8'hF0, 1'b0, 1'b1, {8'h78, 6'b100000, 8'hF0, 6'b000001});
        send_pair(8'h80, 8'h80, 1'b0, 1'b0, {8'h00, 6'b000010, 8'h80, 6'b000010});

        drive_pair(8'h6F, 8'h10, 1'b0, 1'b1);
        drive_pair(8'h6F, 8'h10, 1'b0, 1'b0);
        drive_pair(8'h01, 8'h01, 1'b0, 1'b1);
        drive_pair(8'h0F, 8'h10, 1'b1, 1'b1);
        drive_pair(8'h3F, 8'h31, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            drive_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle();
        repeat (3) @(negedge clk);
        drain("drain_random");

        #1;
        check("hold_out_valid", {7'd0, out_valid}, 8'd0);
        check("hold_y", y, last_exp[27:20]);
        check("hold_y_sum", y_sum, last_exp[13:6]);

        drive_pair(8'h3C, 8'h44, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", {7'd0, out_valid}, 8'd0);
        check("midrst_y", y, 8'd0);
        check("midrst_y_sum", y_sum, 8'd0);
        check("midrst_flags", {flags_mul[3:0], flags_add[3:0]}, 8'd0);
        exp_q.delete();
        #6;
        reset = 1'b0;

        drive_pair(8'h25, 8'h4A, 1'b0, 1'b1);
        drive_pair(8'hC3, 8'h1F, 1'b1, 1'b0);
        drive_pair(8'h5E, 8'hD9, 1'b0, 1'b1);
        idle();
        idle();
        drain("drain_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, queue depth %0d", exp_q.size());
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp_add_mul_unit.md
# fp_add_mul_unit

Registered 8-bit minifloat arithmetic unit. It computes, in the same cycle, the product a*b and the sum or difference a±b of two operands, each with its own 6-bit exception-flag vector. It is the elementary FP datapath for the systolic matrix-multiply processing element: multiply feeds accumulate. Both arithmetic paths are combinational cores followed by one output register stage.

## Interface

Parameters:
- WIDTH, 8, total operand width.
- EXP_WIDTH, 3, exponent field width; bias = 2^(EXP_WIDTH-1)-1 = 3.
- MANT_WIDTH, 4, stored fraction width (hidden bit implicit).

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all registers.
- in_valid  in  1  operands valid this cycle.
- a  in  WIDTH  operand A: {sign, exp, frac}.
- b  in  WIDTH  operand B.
- control  in  1  0 = add (a+b), 1 = subtract (a−b).
- RoundU  in  1  1 = round-to-nearest-ties-to-even, 0 = truncate (toward zero).
- out_valid  out  1  registered copy of in_valid.
- y  out  WIDTH  registered product a*b.
- y_sum  out  WIDTH  registered a±b.
- flags_mul  out  6  registered flags of the product.
- flags_add  out  6  registered flags of the sum.

## Operation

Encoding:
- exp 1..6 is normal: (−1)^s·2^(e−3)·1.f.
- exp 0 is zero or subnormal: (−1)^s·2^(−2)·0.f.
- exp 7 with f=0 is ±Inf; exp 7 with f≠0 is NaN.
- Max finite magnitude 15.5 (x1101111). Min normal 0.25. Min subnormal 2^−6.

Flag bit order:
- [5] invalid.
- [4] overflow.
- [3] underflow: result tiny (below min normal before rounding) and inexact.
- [2] inexact.
- [1] result is zero.
- [0] result is infinite.

Multiply:
- Sign is the XOR of the input signs.
- Exponents are added and the bias subtracted.
- The 5x5 significand product is normalised, then shifted right into the subnormal range when needed, accumulating sticky bits.

Add/sub:
- For subtract, b's sign is inverted.
- Exponents are aligned with guard/round/sticky bits, then magnitudes are added or subtracted.
- The result is normalised by a leading-zero shift, limited so the exponent does not drop below 1; a result below that becomes subnormal.
- An exact zero sum is +0 in both rounding modes. (−0)+(−0) gives −0.

Rounding:
- RoundU=1 rounds to nearest, ties to even.
- RoundU=0 truncates.
- A mantissa carry-out increments the exponent.

Overflow:
- RoundU=1: result is ±Inf (s1110000).
- RoundU=0: result is ±max-finite (s1101111).
- In both modes, overflow and inexact are set.

Specials:
- Any NaN input gives the canonical NaN 01111000. No invalid flag is raised.
- Inf−Inf (effective subtraction) gives NaN with invalid set.
- 0·Inf gives NaN with invalid set.
- Inf ± finite gives that Inf. Inf·nonzero gives ±Inf.
- Exact infinite results set only the [0] flag.

## Timing

- Reset (asynchronous):
  - y, y_sum, flags_mul and flags_add go to 0.
  - out_valid goes to 0.
- Latency is 1 cycle:
  - Inputs are sampled at rising edge N.
  - Results and flags for those inputs are visible after edge N until the next edge.
- Pipeline behaviour:
  - No backpressure: a new operand pair is accepted every cycle.
  - When in_valid=0, the output registers hold their previous values and out_valid=0 on the next cycle.
- Reset asserted mid-stream discards the in-flight result immediately. The first valid output after reset release appears one edge after the first in_valid=1 sample.
- RoundU and control are sampled on the same edge as a/b.

## Test plan

- a=11101111, b=01101111, RoundU=1:
  - Multiply: y=11110000, flags_mul=010101.
  - Add (control=0): y_sum=00000000, flags_add=000010.
  - Subtract (control=1): y_sum=11110000, flags_add=010101.
- a=00010010, b=00100010, RoundU=1:
  - Multiply: y=00001010 (subnormal), flags_mul=001100.
  - Add: y_sum=00101011, flags 0.
  - Subtract: y_sum=10010010, flags 0.
- a=10100101, b=00000000:
  - Multiply: y=10000000, flags_mul=000010.
  - Add: y_sum=10100101, flags 0.
- a=11101111, b=01101111, RoundU=0:
  - Multiply: y=11101111 (max finite), flags_mul=010100.
- a=01110000, b=01110000, control=1:
  - Subtract: y_sum=01111000, flags_add=100000.
  - Multiply: y=01110000, flags_mul=000001.
- Reset timing:
  - Assert reset between clock edges: all outputs go to 0 at once, without waiting for an edge.
  - After release, three back-to-back valid pairs produce three consecutive correct results, each with 1-cycle latency.
